// File: rtl/shifter_pkg.sv
// Shared definitions for the shift arbiter slice: opcode encodings,
// response FSM states and the request bundle carried through the grant mux.
package shifter_pkg;

    localparam logic [1:0] ALUC_SRA = 2'b00;
    localparam logic [1:0] ALUC_SRL = 2'b01;
    localparam logic [1:0] ALUC_SLL = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  aluc;
    } shreq_t;

endpackage

// File: rtl/barrelshifter32.sv
// 32-bit logarithmic barrel shifter: five conditional stages of 1/2/4/8/16.
// aluc: 00 arithmetic right, 01 logical right, 1x logical left.
module barrelshifter32
    import shifter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  aluc,
    output logic [31:0] c
);

    logic [31:0] r;

    always_comb begin
        r = a;
        for (int s = 0; s < 5; s++) begin
            if (b[s]) begin
                if (aluc[1])
                    r = r << (1 << s);
                else if (aluc == ALUC_SRL)
                    r = r >> (1 << s);
                else
                    r = $unsigned($signed(r) >>> (1 << s));
            end
        end
    end

    assign c = r;

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin share of one barrelshifter32 between two requesters, with a
// single-entry registered response slot and saturating per-port grant counters.
module shifter_arbiter
    import shifter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [4:0]       req0_b,
    input  logic [1:0]       req0_aluc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [4:0]       req1_b,
    input  logic [1:0]       req1_aluc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    state_t      state;
    logic        rr_ptr;
    logic        free;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    shreq_t      sel;
    logic [31:0] sh_c;

    // Slot frees either when empty or when the held result drains this cycle.
    // Readies are gated by rst so no requester sees a handshake that reset discards.
    assign free   = (state == ST_IDLE) | rsp_ready;
    assign gnt0   = !rst & free & req0_valid & (!req1_valid | !rr_ptr);
    assign gnt1   = !rst & free & req1_valid & (!req0_valid |  rr_ptr);
    assign accept = gnt0 | gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state == ST_HOLD);

    always_comb begin
        if (gnt1) sel = '{a: req1_a, b: req1_b, aluc: req1_aluc};
        else      sel = '{a: req0_a, b: req0_b, aluc: req0_aluc};
    end

    barrelshifter32 u_shift (
        .a    (sel.a),
        .b    (sel.b),
        .aluc (sel.aluc),
        .c    (sh_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_HOLD;
                        rsp_data <= sh_c;
                        rsp_id   <= gnt1;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        rsp_data <= sh_c;
                        rsp_id   <= gnt1;
                    end else if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         rr_ptr <= 1'b0;
        else if (accept) rr_ptr <= ~gnt1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt0 && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (gnt1 && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed literal checks plus randomized traffic compared every cycle
// against a transaction-level model of the arbiter and shifter.
module tb_shifter_arbiter;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a = '0, req1_a = '0;
    logic [4:0]       req0_b = '0, req1_b = '0;
    logic [1:0]       req0_aluc = '0, req1_aluc = '0;
    logic             rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [31:0]      rsp_data;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    shifter_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_aluc(req1_aluc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-at-a-time reference shift.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int b, input logic [1:0] op);
        logic [31:0] r = a;
        for (int i = 0; i < b; i++) begin
            if (op[1])       r = {r[30:0], 1'b0};
            else if (op[0])  r = {1'b0, r[31:1]};
            else             r = {r[31], r[31:1]};
        end
        return r;
    endfunction

    // Transaction-level model, advanced at each negedge from the inputs seen there.
    bit          armed = 0;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_id;
    int          m_cnt[2];
    int          m_rr;

    always @(negedge clk) begin
        int g;
        g = -1;
        if (!rst && (!m_valid || rsp_ready)) begin
            if (req0_valid && req1_valid) g = m_rr;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        if (armed) begin
            chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            chk("m_rsp_data", rsp_data, m_data);
            chk("m_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            chk("m_cnt0", 32'(grant_cnt0), 32'(m_cnt[0]));
            chk("m_cnt1", 32'(grant_cnt1), 32'(m_cnt[1]));
            chk("m_ready0", {31'd0, req0_ready}, {31'd0, g == 0});
            chk("m_ready1", {31'd0, req1_ready}, {31'd0, g == 1});
        end
        if (rst) begin
            armed = 1; m_valid = 0; m_data = '0; m_id = 0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_rr = 0;
        end else if (g >= 0) begin
            m_data  = (g == 0) ? ref_shift(req0_a, int'(req0_b), req0_aluc)
                               : ref_shift(req1_a, int'(req1_b), req1_aluc);
            m_id    = (g == 1);
            m_valid = 1;
            m_rr    = 1 - g;
            if (m_cnt[g] < CMAX) m_cnt[g]++;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    endtask

    task automatic p0(input logic v, input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_aluc = op;
    endtask

    task automatic p1(input logic v, input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_aluc = op;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] t4_a   [6] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h80000000, 32'h80000000};
    logic [4:0]  t4_b   [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
    logic [1:0]  t4_op  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [31:0] t4_exp [6] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000001, 32'hFFFFFFFF};

    initial begin
        cyc(); do_reset();
        chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_data", rsp_data, 32'd0);
        chk("reset_id", {31'd0, rsp_id}, 32'd0);
        chk("reset_cnt0", 32'(grant_cnt0), 32'd0);
        chk("reset_cnt1", 32'(grant_cnt1), 32'd0);

        // Port 0 alone, SRL by 3.
        rsp_ready = 1'b1;
        p0(1, 32'hFFFFFFFF, 5'd3, 2'b01);
        #1 chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
        cyc();
        p0(0, '0, '0, '0);
        chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_data", rsp_data, 32'h1FFFFFFF);
        chk("t1_id", {31'd0, rsp_id}, 32'd0);
        chk("t1_cnt0", 32'(grant_cnt0), 32'd1);

        // Both ports every cycle: strict alternation, no bubbles.
        do_reset();
        p0(1, 32'h80000000, 5'd4, 2'b00);
        p1(1, 32'h00000001, 5'd31, 2'b10);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t2_id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("t2_data", rsp_data, (i % 2 == 0) ? 32'hF8000000 : 32'h80000000);
        end

        // Backpressure with P1 pending; held result is the last P1 result.
        p0(0, '0, '0, '0);
        p1(1, 32'h12345678, 5'd8, 2'b01);
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_ready1_low", {31'd0, req1_ready}, 32'd0);
            cyc();
            chk("t3_hold_data", rsp_data, 32'h80000000);
            chk("t3_hold_id", {31'd0, rsp_id}, 32'd1);
        end
        rsp_ready = 1'b1;
        #1 chk("t3_ready1_rise", {31'd0, req1_ready}, 32'd1);
        cyc();
        p1(0, '0, '0, '0);
        chk("t3_data", rsp_data, 32'h00123456);
        chk("t3_id", {31'd0, rsp_id}, 32'd1);

        // Shift-amount boundaries.
        for (int k = 0; k < 6; k++) begin
            p0(1, t4_a[k], t4_b[k], t4_op[k]);
            cyc();
            chk("t4_data", rsp_data, t4_exp[k]);
        end
        p0(0, '0, '0, '0);

        // Reset while holding with both ports valid.
        p0(1, 32'h0000F00F, 5'd4, 2'b10);
        p1(1, 32'hF00F0000, 5'd4, 2'b01);
        rsp_ready = 1'b0;
        cyc();
        chk("t5_hold", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0; rsp_ready = 1'b1;
        chk("t5_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5_cnt0", 32'(grant_cnt0), 32'd0);
        chk("t5_cnt1", 32'(grant_cnt1), 32'd0);
        #1 chk("t5_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t5_ready1", {31'd0, req1_ready}, 32'd0);
        cyc();
        chk("t5_first_id", {31'd0, rsp_id}, 32'd0);
        chk("t5_first_data", rsp_data, 32'h000F00F0);
        p1(0, '0, '0, '0);

        // Counter saturation.
        do_reset();
        p0(1, 32'h00000003, 5'd1, 2'b10);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t6_cnt0", 32'(grant_cnt0), (i + 1 < CMAX) ? 32'(i + 1) : 32'(CMAX));
        end
        p0(0, '0, '0, '0);

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_a     = $urandom;
            req1_a     = $urandom;
            req0_b     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            req1_b     = ($urandom_range(0, 7) == 0) ? 5'd0  : 5'($urandom);
            req0_aluc  = 2'($urandom);
            req1_aluc  = 2'($urandom);
            cyc();
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
